decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/Zicsr/Zifencei decode stage: combinational decode on capture, followed by a
// registered output stage (2-entry skid buffer when SKID=1, single register when SKID=0).
module decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [18:0]     out_ctrl,
  output logic [2:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      dbg_state
);

  localparam int C_ALU_IMM  = 0;
  localparam int C_ALU_SUB  = 1;
  localparam int C_ALU_SRA  = 2;
  localparam int C_RD_W     = 3;
  localparam int C_LD_UPPER = 4;
  localparam int C_ADD_PC   = 5;
  localparam int C_JMP_REG  = 6;
  localparam int C_BRANCH   = 7;
  localparam int C_JMP      = 8;
  localparam int C_LOAD     = 9;
  localparam int C_STORE    = 10;
  localparam int C_FENCE    = 11;
  localparam int C_FENCEI   = 12;
  localparam int C_CSR      = 13;
  localparam int C_CSR_ZIMM = 14;
  localparam int C_CSR_W    = 15;
  localparam int C_CSR_SET  = 16;
  localparam int C_CSR_CLR  = 17;
  localparam int C_ILLEGAL  = 18;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [18:0]     ctrl;
    logic [2:0]      alu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        sh_log_ok;
  logic        sh_ari_ok;
  logic        bad;
  logic [18:0] d_ctrl;
  logic [2:0]  d_op;
  logic [31:0] d_imm32;
  entry_t      dec;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  // RV64 shifts take a 6-bit shamt, so bit 25 belongs to the amount rather than funct7.
  assign sh_log_ok = (XLEN == 64) ? (in_inst[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sh_ari_ok = (XLEN == 64) ? (in_inst[31:26] == 6'b010000) : (f7 == 7'b0100000);

  always_comb begin
    d_ctrl  = '0;
    d_op    = '0;
    bad     = 1'b0;
    d_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    case (opcode)
      OP_LUI: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_LD_UPPER] = 1'b1;
        d_imm32 = {in_inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_ADD_PC] = 1'b1;
        d_imm32 = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_JMP] = 1'b1;
        d_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_JMP] = 1'b1; d_ctrl[C_JMP_REG] = 1'b1;
        bad = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        d_ctrl[C_BRANCH] = 1'b1; d_op = f3;
        d_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_LOAD] = 1'b1; d_op = f3;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        d_ctrl[C_STORE] = 1'b1; d_op = f3;
        d_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        bad = (f3 > 3'b010);
      end
      OP_IMM: begin
        d_ctrl[C_RD_W] = 1'b1; d_ctrl[C_ALU_IMM] = 1'b1; d_op = f3;
        if (f3 == 3'b001) begin
          bad = !sh_log_ok;
        end else if (f3 == 3'b101) begin
          if (sh_ari_ok) d_ctrl[C_ALU_SRA] = 1'b1;
          else           bad = !sh_log_ok;
        end
      end
      OP_REG: begin
        d_ctrl[C_RD_W] = 1'b1; d_op = f3;
        if (f7 == 7'b0100000 && f3 == 3'b000)      d_ctrl[C_ALU_SUB] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b101) d_ctrl[C_ALU_SRA] = 1'b1;
        else                                       bad = (f7 != 7'b0000000);
      end
      OP_FENCE: begin
        if (f3 == 3'b000)      d_ctrl[C_FENCE]  = 1'b1;
        else if (f3 == 3'b001) d_ctrl[C_FENCEI] = 1'b1;
        else                   bad = 1'b1;
      end
      OP_SYSTEM: begin
        if (f3[1:0] == 2'b00) begin
          bad = 1'b1;
        end else begin
          d_ctrl[C_RD_W]      = 1'b1;
          d_ctrl[C_CSR]       = 1'b1;
          d_ctrl[C_CSR_ZIMM]  = f3[2];
          d_ctrl[C_CSR_W]     = (f3[1:0] == 2'b01);
          d_ctrl[C_CSR_SET]   = (f3[1:0] == 2'b10);
          d_ctrl[C_CSR_CLR]   = (f3[1:0] == 2'b11);
          if (f3[2]) d_imm32 = {27'b0, in_inst[19:15]};
        end
      end
      default: bad = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      d_ctrl            = '0;
      d_ctrl[C_ILLEGAL] = 1'b1;
      d_op              = '0;
    end
  end

  assign dec = {in_pc, d_ctrl, d_op, in_inst[11:7], in_inst[19:15], in_inst[24:20],
                XLEN'($signed(d_imm32))};

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_* stay frozen while out_valid && !out_ready.
  state_t state, state_nx;
  entry_t head, head_nx, skid, skid_nx;
  logic   in_ready_q;
  logic   in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    head_nx  = head;
    skid_nx  = skid;
    case (state)
      ST_EMPTY: if (in_xfer) begin
        head_nx  = dec;
        state_nx = ST_ONE;
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          head_nx = dec;
        end else if (in_xfer) begin
          skid_nx  = dec;
          state_nx = ST_TWO;
        end else if (out_xfer) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_TWO: if (out_xfer) begin
        head_nx  = skid;
        state_nx = ST_ONE;
      end
      default: state_nx = ST_EMPTY;
    endcase
    if (flush) state_nx = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      head       <= '0;
      skid       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      head       <= head_nx;
      skid       <= skid_nx;
      in_ready_q <= (state_nx != ST_TWO);
    end
  end

  // Reset gating keeps both sides quiet during the reset cycle itself.
  assign in_ready   = rst ? 1'b0 : ((SKID != 0) ? in_ready_q : (!out_valid || out_ready));
  assign out_valid  = (state != ST_EMPTY) && !rst;
  assign out_pc     = head.pc;
  assign out_ctrl   = head.ctrl;
  assign out_alu_op = head.alu_op;
  assign out_rd     = head.rd;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_imm    = head.imm;
  assign dbg_state  = state;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: XLEN=32 and XLEN=64 instances (both SKID=1) driven
// from the same stimulus, checked against hand-computed control words and immediates.
module tb_decode_stage;

  localparam logic [18:0] ALU_IMM  = 19'h00001;
  localparam logic [18:0] ALU_SUB  = 19'h00002;
  localparam logic [18:0] ALU_SRA  = 19'h00004;
  localparam logic [18:0] RD_W     = 19'h00008;
  localparam logic [18:0] LD_UPPER = 19'h00010;
  localparam logic [18:0] ADD_PC   = 19'h00020;
  localparam logic [18:0] JMP_REG  = 19'h00040;
  localparam logic [18:0] BRANCH   = 19'h00080;
  localparam logic [18:0] JMP      = 19'h00100;
  localparam logic [18:0] LOAD     = 19'h00200;
  localparam logic [18:0] STORE    = 19'h00400;
  localparam logic [18:0] FENCE    = 19'h00800;
  localparam logic [18:0] FENCEI   = 19'h01000;
  localparam logic [18:0] CSR      = 19'h02000;
  localparam logic [18:0] CSR_ZIMM = 19'h04000;
  localparam logic [18:0] CSR_W    = 19'h08000;
  localparam logic [18:0] CSR_SET  = 19'h10000;
  localparam logic [18:0] CSR_CLR  = 19'h20000;
  localparam logic [18:0] ILLEGAL  = 19'h40000;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_IMM = 7'b0010011, OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111, OPC_SYS = 7'b1110011;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy32, ov32;
  logic [31:0] pc32, imm32;
  logic [18:0] ctrl32;
  logic [2:0]  op32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [1:0]  st32;

  logic        rdy64, ov64;
  logic [63:0] pc64, imm64;
  logic [18:0] ctrl64;
  logic [2:0]  op64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [1:0]  st64;

  decode_stage #(.XLEN(32), .SKID(1)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(pc32), .out_ctrl(ctrl32), .out_alu_op(op32), .out_rd(rd32),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_imm(imm32), .dbg_state(st32)
  );

  decode_stage #(.XLEN(64), .SKID(1)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
    .out_pc(pc64), .out_ctrl(ctrl64), .out_alu_op(op64), .out_rd(rd64),
    .out_rs1(rs1_64), .out_rs2(rs2_64), .out_imm(imm64), .dbg_state(st64)
  );

  int          n_checks;
  int          n_errors;
  logic [63:0] exp_q[$];
  logic [63:0] pc_ctr;
  logic        acc;
  int          iters;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 5'd3, 5'd2, f3, 5'd1, opc};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_inst  = '0;
  endtask

  task automatic issue(input logic [31:0] inst);
    drive(inst, pc_ctr);
    next_cycle();
    idle();
    @(negedge clk);
  endtask

  task automatic sweep_one(input string tag, input logic [31:0] inst,
                           input logic [18:0] exp_ctrl, input logic [2:0] exp_op);
    issue(inst);
    check({tag, "_valid"}, ov32, 1);
    check({tag, "_pc"}, pc32, pc_ctr[31:0]);
    check({tag, "_ctrl32"}, ctrl32, exp_ctrl);
    check({tag, "_op32"}, op32, exp_op);
    check({tag, "_ctrl64"}, ctrl64, exp_ctrl);
    check({tag, "_op64"}, op64, exp_op);
    pc_ctr += 64'd4;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; pc_ctr = 64'h1000;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", rdy32, 0);
    check("rst_valid", ov32, 0);
    check("rst_ctrl", ctrl32, 0);
    check("rst_op", op32, 0);
    check("rst_pc", pc64, 0);
    check("rst_imm", imm64, 0);
    check("rst_regs", {rd32, rs1_32, rs2_32}, 0);
    check("rst_state", st32, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready32", rdy32, 1);
    check("post_rst_ready64", rdy64, 1);

    out_ready = 1'b1;
    sweep_one("lui",    enc(7'h12, 3'b101, OPC_LUI),   RD_W | LD_UPPER, 3'b000);
    sweep_one("auipc",  enc(7'h05, 3'b010, OPC_AUIPC), RD_W | ADD_PC, 3'b000);
    sweep_one("jal",    enc(7'h40, 3'b011, OPC_JAL),   RD_W | JMP, 3'b000);
    sweep_one("jalr",   enc(7'h00, 3'b000, OPC_JALR),  RD_W | JMP | JMP_REG, 3'b000);
    sweep_one("beq",    enc(7'h00, 3'b000, OPC_BR),    BRANCH, 3'b000);
    sweep_one("bne",    enc(7'h00, 3'b001, OPC_BR),    BRANCH, 3'b001);
    sweep_one("blt",    enc(7'h00, 3'b100, OPC_BR),    BRANCH, 3'b100);
    sweep_one("bge",    enc(7'h00, 3'b101, OPC_BR),    BRANCH, 3'b101);
    sweep_one("bltu",   enc(7'h00, 3'b110, OPC_BR),    BRANCH, 3'b110);
    sweep_one("bgeu",   enc(7'h00, 3'b111, OPC_BR),    BRANCH, 3'b111);
    sweep_one("lb",     enc(7'h00, 3'b000, OPC_LD),    RD_W | LOAD, 3'b000);
    sweep_one("lh",     enc(7'h00, 3'b001, OPC_LD),    RD_W | LOAD, 3'b001);
    sweep_one("lw",     enc(7'h00, 3'b010, OPC_LD),    RD_W | LOAD, 3'b010);
    sweep_one("lbu",    enc(7'h00, 3'b100, OPC_LD),    RD_W | LOAD, 3'b100);
    sweep_one("lhu",    enc(7'h00, 3'b101, OPC_LD),    RD_W | LOAD, 3'b101);
    sweep_one("sb",     enc(7'h00, 3'b000, OPC_ST),    STORE, 3'b000);
    sweep_one("sh",     enc(7'h00, 3'b001, OPC_ST),    STORE, 3'b001);
    sweep_one("sw",     enc(7'h00, 3'b010, OPC_ST),    STORE, 3'b010);
    sweep_one("addi",   enc(7'h00, 3'b000, OPC_IMM),   RD_W | ALU_IMM, 3'b000);
    sweep_one("slti",   enc(7'h00, 3'b010, OPC_IMM),   RD_W | ALU_IMM, 3'b010);
    sweep_one("sltiu",  enc(7'h00, 3'b011, OPC_IMM),   RD_W | ALU_IMM, 3'b011);
    sweep_one("xori",   enc(7'h00, 3'b100, OPC_IMM),   RD_W | ALU_IMM, 3'b100);
    sweep_one("ori",    enc(7'h00, 3'b110, OPC_IMM),   RD_W | ALU_IMM, 3'b110);
    sweep_one("andi",   enc(7'h00, 3'b111, OPC_IMM),   RD_W | ALU_IMM, 3'b111);
    sweep_one("slli",   enc(7'h00, 3'b001, OPC_IMM),   RD_W | ALU_IMM, 3'b001);
    sweep_one("srli",   enc(7'h00, 3'b101, OPC_IMM),   RD_W | ALU_IMM, 3'b101);
    sweep_one("srai",   enc(7'h20, 3'b101, OPC_IMM),   RD_W | ALU_IMM | ALU_SRA, 3'b101);
    sweep_one("add",    enc(7'h00, 3'b000, OPC_REG),   RD_W, 3'b000);
    check("add_regs", {rd32, rs1_32, rs2_32}, {5'd1, 5'd2, 5'd3});
    sweep_one("sub",    enc(7'h20, 3'b000, OPC_REG),   RD_W | ALU_SUB, 3'b000);
    sweep_one("sll",    enc(7'h00, 3'b001, OPC_REG),   RD_W, 3'b001);
    sweep_one("slt",    enc(7'h00, 3'b010, OPC_REG),   RD_W, 3'b010);
    sweep_one("sltu",   enc(7'h00, 3'b011, OPC_REG),   RD_W, 3'b011);
    sweep_one("xor",    enc(7'h00, 3'b100, OPC_REG),   RD_W, 3'b100);
    sweep_one("srl",    enc(7'h00, 3'b101, OPC_REG),   RD_W, 3'b101);
    sweep_one("sra",    enc(7'h20, 3'b101, OPC_REG),   RD_W | ALU_SRA, 3'b101);
    sweep_one("or",     enc(7'h00, 3'b110, OPC_REG),   RD_W, 3'b110);
    sweep_one("and",    enc(7'h00, 3'b111, OPC_REG),   RD_W, 3'b111);
    sweep_one("fence",  enc(7'h00, 3'b000, OPC_FENCE), FENCE, 3'b000);
    sweep_one("fencei", enc(7'h00, 3'b001, OPC_FENCE), FENCEI, 3'b000);
    sweep_one("csrrw",  enc(7'h1a, 3'b001, OPC_SYS),   RD_W | CSR | CSR_W, 3'b000);
    sweep_one("csrrs",  enc(7'h1a, 3'b010, OPC_SYS),   RD_W | CSR | CSR_SET, 3'b000);
    sweep_one("csrrc",  enc(7'h1a, 3'b011, OPC_SYS),   RD_W | CSR | CSR_CLR, 3'b000);
    sweep_one("csrrwi", enc(7'h1a, 3'b101, OPC_SYS),   RD_W | CSR | CSR_ZIMM | CSR_W, 3'b000);
    sweep_one("csrrsi", enc(7'h1a, 3'b110, OPC_SYS),   RD_W | CSR | CSR_ZIMM | CSR_SET, 3'b000);
    sweep_one("csrrci", enc(7'h1a, 3'b111, OPC_SYS),   RD_W | CSR | CSR_ZIMM | CSR_CLR, 3'b000);

    // Illegal encodings
    issue(32'h0000_0000);
    check("ill_zero32", ctrl32, ILLEGAL);
    check("ill_zero64", ctrl64, ILLEGAL);
    issue(32'hFFFF_FFFF);
    check("ill_ones32", ctrl32, ILLEGAL);
    check("ill_ones64", ctrl64, ILLEGAL);
    issue(32'h0200_9093);
    check("slli32_ill", ctrl32, ILLEGAL);
    check("slli64_ok", ctrl64, RD_W | ALU_IMM);
    check("slli64_imm", imm64, 64'd32);
    issue(enc(7'h01, 3'b000, OPC_REG));
    check("ill_funct7", ctrl32, ILLEGAL);
    issue(32'hFFF0_0092);
    check("ill_lowbits", ctrl32, ILLEGAL);

    // Immediates
    issue(32'hFFF0_0093);
    check("imm_addi32", imm32, 32'hFFFF_FFFF);
    check("imm_addi64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("imm_addi_ctrl", ctrl32, RD_W | ALU_IMM);
    issue({12'h340, 5'd31, 3'b101, 5'd0, 7'b1110011});
    check("imm_zimm32", imm32, 32'd31);
    check("imm_zimm64", imm64, 64'd31);
    check("imm_zimm_ctrl", ctrl32, RD_W | CSR | CSR_ZIMM | CSR_W);
    issue({7'b1111111, 5'd3, 5'd2, 3'b010, 5'b11000, 7'b0100011});
    check("imm_store", imm32, 32'hFFFF_FFF8);
    issue({1'b1, 6'b111111, 5'd3, 5'd2, 3'b000, 4'b1111, 1'b1, 7'b1100011});
    check("imm_branch64", imm64, 64'hFFFF_FFFF_FFFF_FFFE);
    issue({1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111});
    check("imm_jal", imm32, 32'h0000_0800);
    issue({20'h80000, 5'd1, 7'b0110111});
    check("imm_lui32", imm32, 32'h8000_0000);
    check("imm_lui64", imm64, 64'hFFFF_FFFF_8000_0000);

    // Backpressure: addi, slti, xori with out_ready low
    next_cycle();
    out_ready = 1'b0;
    exp_q.delete();
    drive(enc(7'h00, 3'b000, OPC_IMM), 64'h100); exp_q.push_back(64'h100);
    next_cycle();
    drive(enc(7'h00, 3'b010, OPC_IMM), 64'h104); exp_q.push_back(64'h104);
    @(negedge clk);
    check("bp_ready_one", rdy32, 1);
    next_cycle();
    drive(enc(7'h00, 3'b100, OPC_IMM), 64'h108); exp_q.push_back(64'h108);
    @(negedge clk);
    check("bp_ready_two32", rdy32, 0);
    check("bp_ready_two64", rdy64, 0);
    check("bp_state", st32, 2);
    check("bp_hold_pc", pc32, 32'h100);
    check("bp_hold_ctrl", ctrl32, RD_W | ALU_IMM);
    next_cycle();
    @(negedge clk);
    check("bp_hold_pc2", pc64, 64'h100);
    check("bp_hold_ready", rdy32, 0);
    next_cycle();
    out_ready = 1'b1;
    iters = 0;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      acc = in_valid && rdy32;
      if (ov32 && out_ready) check("bp_order", pc32, exp_q.pop_front());
      iters++;
      next_cycle();
      if (acc) idle();
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_cycles", iters, 3);

    // Flush while holding two entries
    out_ready = 1'b0;
    drive(enc(7'h00, 3'b000, OPC_REG), 64'h200);
    next_cycle();
    drive(enc(7'h20, 3'b000, OPC_REG), 64'h204);
    next_cycle();
    drive(enc(7'h00, 3'b100, OPC_REG), 64'h208);
    flush = 1'b1;
    @(negedge clk);
    check("fl2_pre_state", st32, 2);
    next_cycle();
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("fl2_valid32", ov32, 0);
    check("fl2_valid64", ov64, 0);
    check("fl2_ready", rdy32, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check("fl2_never", ov32, 0);
    end

    // Flush in ONE with the incoming instruction accepted by handshake
    out_ready = 1'b0;
    drive(enc(7'h00, 3'b000, OPC_REG), 64'h300);
    next_cycle();
    drive(enc(7'h00, 3'b111, OPC_REG), 64'h304);
    flush = 1'b1;
    @(negedge clk);
    check("fl1_pre_ready", rdy32, 1);
    next_cycle();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("fl1_valid", ov32, 0);
    next_cycle();
    @(negedge clk);
    check("fl1_never", ov32, 0);
    drive(enc(7'h00, 3'b110, OPC_IMM), 64'h308);
    next_cycle();
    idle();
    @(negedge clk);
    check("fl1_resume_valid", ov32, 1);
    check("fl1_resume_pc", pc32, 32'h308);

    // Reset with two held entries
    next_cycle();
    out_ready = 1'b0;
    drive(enc(7'h00, 3'b000, OPC_REG), 64'h400);
    next_cycle();
    drive(enc(7'h20, 3'b000, OPC_REG), 64'h404);
    next_cycle();
    idle();
    @(negedge clk);
    check("rm_pre_state", st32, 2);
    next_cycle();
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rm_ready_in_rst", rdy32, 0);
    check("rm_valid_in_rst", ov32, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rm_valid", ov32, 0);
    check("rm_ctrl", ctrl32, 0);
    check("rm_ctrl64", ctrl64, 0);
    check("rm_ready", rdy32, 1);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check("rm_never", ov64, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
